// File: rtl/piso_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer_tx
// Purpose  : Parallel-in / serial-out transmitter. A WIDTH-bit word is taken
//            through a valid/ready handshake and shifted out one bit per
//            clock on q, framed by sout_valid, followed by a one-cycle done
//            pulse in the first idle cycle after the frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      : data word width, 2..32
//   MSB_FIRST  : 1 = pdata[WIDTH-1] leaves first, 0 = pdata[0] leaves first
//   IDLE_LEVEL : level held on q outside a frame
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   pdata      : parallel word, sampled only on the handshake edge
//   load_valid : producer offers a word
//   load_ready : block accepts a word (IDLE only, out of reset)
//   q          : registered serial data
//   sout_valid : registered frame qualifier
//   busy       : block is not in IDLE
//   done       : one-cycle pulse after the last frame bit
// Build option
//   PISO_PARITY_EN : when defined, an even-parity bit follows the data bits
//                    inside the frame (frame length WIDTH+1)
// ============================================================================
module piso_serializer_tx #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    // Counter must hold the value WIDTH itself.
    localparam int                 c_cnt_w     = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_first_cnt = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] c_st_parity = 2'd2;
`endif

    logic [1:0]         r_state_q,      w_state_d;
    logic [WIDTH-1:0]   r_shift_q,      w_shift_d;
    logic [c_cnt_w-1:0] r_cnt_q,        w_cnt_d;
    logic               r_q_q,          w_q_d;
    logic               r_sout_valid_q, w_sout_valid_d;
    logic               r_done_q,       w_done_d;
`ifdef PISO_PARITY_EN
    logic               r_parity_q,     w_parity_d;
`endif

    logic               w_load;
    logic               w_first_bit;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_shift_adv;

    // Bit ordering. The shift register holds the captured word as-is; the
    // bit on q is always one position ahead of the register's edge, so the
    // "next" bit is taken one index in from the outgoing end.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_first_bit = pdata[WIDTH-1];
            assign w_next_bit  = r_shift_q[WIDTH-2];
            assign w_shift_adv = {r_shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit = pdata[0];
            assign w_next_bit  = r_shift_q[1];
            assign w_shift_adv = {1'b0, r_shift_q[WIDTH-1:1]};
        end
    endgenerate

    // Ready is withheld while reset is asserted so no handshake is ever
    // advertised during reset.
    assign load_ready = (r_state_q == c_st_idle) & rst;
    assign w_load     = load_valid & load_ready;

    always_comb begin
        w_state_d      = r_state_q;
        w_shift_d      = r_shift_q;
        w_cnt_d        = r_cnt_q;
        w_q_d          = IDLE_LEVEL;
        w_sout_valid_d = 1'b0;
        w_done_d       = 1'b0;
`ifdef PISO_PARITY_EN
        w_parity_d     = r_parity_q;
`endif
        case (r_state_q)
            c_st_idle: begin
                if (w_load) begin
                    w_shift_d      = pdata;
                    w_q_d          = w_first_bit;
                    w_sout_valid_d = 1'b1;
                    w_cnt_d        = c_first_cnt;
                    w_state_d      = c_st_shift;
`ifdef PISO_PARITY_EN
                    w_parity_d     = ^pdata;
`endif
                end
            end
            c_st_shift: begin
                if (r_cnt_q == c_last_cnt) begin
                    // Last data bit has been on q for one cycle; drop the
                    // word so nothing of it survives the frame.
                    w_shift_d = '0;
                    w_cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    w_state_d      = c_st_parity;
                    w_q_d          = r_parity_q;
                    w_sout_valid_d = 1'b1;
`else
                    w_state_d = c_st_idle;
                    w_done_d  = 1'b1;
`endif
                end else begin
                    w_shift_d      = w_shift_adv;
                    w_q_d          = w_next_bit;
                    w_sout_valid_d = 1'b1;
                    w_cnt_d        = r_cnt_q + c_first_cnt;
                end
            end
`ifdef PISO_PARITY_EN
            c_st_parity: begin
                w_state_d  = c_st_idle;
                w_done_d   = 1'b1;
                w_parity_d = 1'b0;
            end
`endif
            default: begin
                w_state_d = c_st_idle;
                w_shift_d = '0;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q      <= c_st_idle;
            r_shift_q      <= '0;
            r_cnt_q        <= '0;
            r_q_q          <= IDLE_LEVEL;
            r_sout_valid_q <= 1'b0;
            r_done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity_q     <= 1'b0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_shift_q      <= w_shift_d;
            r_cnt_q        <= w_cnt_d;
            r_q_q          <= w_q_d;
            r_sout_valid_q <= w_sout_valid_d;
            r_done_q       <= w_done_d;
`ifdef PISO_PARITY_EN
            r_parity_q     <= w_parity_d;
`endif
        end
    end

    assign q          = r_q_q;
    assign sout_valid = r_sout_valid_q;
    assign done       = r_done_q;
    assign busy       = (r_state_q != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer_tx
// Purpose  : Self-checking bench for piso_serializer_tx. Two instances share
//            the stimulus: one MSB-first with idle level 0, one LSB-first
//            with idle level 1. A queue-based frame model predicts q,
//            sout_valid, busy, done and load_ready every cycle; directed
//            frames are also compared as whole words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer_tx;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam bit c_par_en = 1'b1;
`else
    localparam bit c_par_en = 1'b0;
`endif
    localparam int         c_flen = W + (c_par_en ? 1 : 0);
    // {msb instance idle level, lsb instance idle level}
    localparam logic [1:0] c_idle = 2'b01;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pdata = '0;
    logic         load_valid = 1'b0;

    logic rdy_m, q_m, sv_m, busy_m, done_m;
    logic rdy_l, q_l, sv_l, busy_l, done_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_serializer_tx #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .pdata      (pdata),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .q          (q_m),
        .sout_valid (sv_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_serializer_tx #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .pdata      (pdata),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .q          (q_l),
        .sout_valid (sv_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: on acceptance the whole frame is expanded into a
    // queue of bit pairs {msb-first bit, lsb-first bit}; one entry is
    // presented per cycle, and the cycle after the queue runs dry is the
    // done cycle.
    // ------------------------------------------------------------------
    logic [1:0] pend[$];
    logic [1:0] m_q    = c_idle;
    logic       m_busy = 1'b0;
    logic       m_sv   = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            m_busy = 1'b0; m_sv = 1'b0; m_done = 1'b0; m_q = c_idle;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (load_valid) begin
                pend.delete();
                for (int k = 0; k < W; k++) pend.push_back({pdata[W-1-k], pdata[k]});
                if (c_par_en) pend.push_back({2{^pdata}});
                m_q = pend.pop_front();
                m_sv = 1'b1; m_busy = 1'b1;
            end else begin
                m_q = c_idle; m_sv = 1'b0;
            end
        end else if (pend.size() > 0) begin
            m_q = pend.pop_front();
        end else begin
            m_busy = 1'b0; m_sv = 1'b0; m_done = 1'b1; m_q = c_idle;
        end
    end

    // Cycle checker, sampled 2 time units after the active edge.
    always @(posedge clk) begin
        #2;
        chk("q_msb",    32'(q_m),    32'(m_q[1]));
        chk("q_lsb",    32'(q_l),    32'(m_q[0]));
        chk("sv_msb",   32'(sv_m),   32'(m_sv));
        chk("sv_lsb",   32'(sv_l),   32'(m_sv));
        chk("busy_msb", 32'(busy_m), 32'(m_busy));
        chk("busy_lsb", 32'(busy_l), 32'(m_busy));
        chk("done_msb", 32'(done_m), 32'(m_done));
        chk("done_lsb", 32'(done_l), 32'(m_done));
        chk("rdy_msb",  32'(rdy_m),  32'(!m_busy && rst));
        chk("rdy_lsb",  32'(rdy_l),  32'(!m_busy && rst));
    end

    // Expected serial word as it would be assembled by shifting each q bit
    // in from the right: parity (if any) lands in bit 0.
    function automatic logic [8:0] exp_frame(input logic [7:0] d, input bit msb);
        logic [7:0] ord;
        for (int k = 0; k < 8; k++) ord[k] = msb ? d[k] : d[7-k];
        if (c_par_en) return {ord, ^d};
        return {1'b0, ord};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge with the first bit on q.
    task automatic load_word(input logic [7:0] d, input bit hold, input logic [7:0] d_after);
        pdata = d; load_valid = 1'b1;
        @(negedge clk);
        pdata = d_after;
        if (!hold) load_valid = 1'b0;
    endtask

    // Collects the frame in progress; returns at the negedge of the done cycle.
    task automatic collect(output logic [8:0] gm, output logic [8:0] gl, output int nb);
        gm = '0; gl = '0; nb = 0;
        for (int i = 0; i < 20 && sv_m; i++) begin
            gm = {gm[7:0], q_m};
            gl = {gl[7:0], q_l};
            nb++;
            @(negedge clk);
        end
        if (sv_m) chk("frame_timeout", 32'(sv_m), 32'd0);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d,
                               input logic [8:0] gm, input logic [8:0] gl, input int nb);
        chk({tag, "_bits_msb"}, 32'(gm),     32'(exp_frame(d, 1'b1)));
        chk({tag, "_bits_lsb"}, 32'(gl),     32'(exp_frame(d, 1'b0)));
        chk({tag, "_len"},      32'(nb),     32'(c_flen));
        chk({tag, "_done"},     32'(done_m), 32'd1);
        chk({tag, "_q_idle"},   32'(q_m),    32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && busy_m; i++) @(negedge clk);
        if (busy_m) chk("idle_timeout", 32'(busy_m), 32'd0);
    endtask

    logic [8:0] gm, gl;
    int         nb;

    initial begin
        // Reset held with a load pending.
        rst = 1'b0; load_valid = 1'b1; pdata = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_q",    32'(q_m),    32'd0);
        chk("rst_sv",   32'(sv_m),   32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        rst = 1'b1; load_valid = 1'b0;
        #1;
        chk("rdy_after_rst_msb", 32'(rdy_m), 32'd1);
        chk("rdy_after_rst_lsb", 32'(rdy_l), 32'd1);
        @(negedge clk);

        // Single frames, both bit orders.
        load_word(8'hC1, 1'b0, 8'h3C);
        collect(gm, gl, nb);
        frame_check("c1", 8'hC1, gm, gl, nb);
        @(negedge clk);
        chk("c1_done_clear", 32'(done_m), 32'd0);

        wait_idle();
        load_word(8'h1E, 1'b0, 8'h00);
        collect(gm, gl, nb);
        frame_check("1e", 8'h1E, gm, gl, nb);

        // Back-to-back with load_valid held; pdata swapped mid-frame.
        @(negedge clk);
        wait_idle();
        load_word(8'hFF, 1'b1, 8'h00);
        collect(gm, gl, nb);
        frame_check("b2b_ff", 8'hFF, gm, gl, nb);
        chk("b2b_gap_rdy", 32'(rdy_m), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("b2b_second_sv", 32'(sv_m), 32'd1);
        collect(gm, gl, nb);
        frame_check("b2b_00", 8'h00, gm, gl, nb);

        // Reset while the 4th bit of 8'hA5 is on q.
        @(negedge clk);
        wait_idle();
        load_word(8'hA5, 1'b0, 8'hFF);
        repeat (3) @(negedge clk);
        chk("mid_sv_before", 32'(sv_m), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_q_msb", 32'(q_m),    32'd0);
        chk("mid_rst_q_lsb", 32'(q_l),    32'd1);
        chk("mid_rst_sv",    32'(sv_m),   32'd0);
        chk("mid_rst_busy",  32'(busy_m), 32'd0);
        chk("mid_rst_done",  32'(done_m), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_word(8'h5A, 1'b0, 8'h00);
        collect(gm, gl, nb);
        frame_check("5a", 8'h5A, gm, gl, nb);

        // Parity-sensitive word (parity 0).
        @(negedge clk);
        wait_idle();
        load_word(8'h03, 1'b0, 8'hFF);
        collect(gm, gl, nb);
        frame_check("03", 8'h03, gm, gl, nb);

        // Randomized traffic with occasional resets; checked by the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            pdata      = 8'($urandom);
            load_valid = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b0;
        repeat (25) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer_tx.md
Name: piso_serializer_tx

Overview:
- Parallel-in, serial-out transmitter that feeds our serial shift-register receive chains.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per clock on q.
- Drives a framing qualifier (sout_valid) and a one-cycle completion pulse (done).
- Sits between a parallel producer and any serial-in consumer clocked by the same clk.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift pdata[WIDTH-1] first; 0 = shift pdata[0] first.
IDLE_LEVEL, 0, value driven on q whenever no frame is being transmitted.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-low (rst==0 resets).
pdata  input  WIDTH  parallel word to transmit; sampled only on the handshake edge.
load_valid  input  1  producer has a word on pdata.
load_ready  output  1  block can accept a word; high only in IDLE.
q  output  1  serial data out, registered.
sout_valid  output  1  high while q carries a frame bit, registered.
busy  output  1  high in every state other than IDLE.
done  output  1  one-cycle pulse after the last frame bit has been driven.

Behaviour:
- Reset, asynchronous, while rst==0:
  - state=IDLE, shift register=0, bit counter=0.
  - q=IDLE_LEVEL, sout_valid=0, busy=0, done=0.
  - load_ready becomes 1 once rst is released.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - load_ready=1.
  - Handshake occurs on a rising edge with load_valid==1 && load_ready==1.
  - At that edge: capture pdata into the shift register, set q to the first bit (per MSB_FIRST), set sout_valid=1, set counter=1, go to SHIFT.
- Latency: the first bit appears on q in the cycle immediately after the handshake edge.
- SHIFT:
  - At each edge, advance the shift register and present the next bit on q.
  - While counter<WIDTH, increment the counter.
  - On the edge after the WIDTH-th bit has been driven (counter==WIDTH), go to IDLE (or PARITY, see below): q=IDLE_LEVEL, sout_valid=0, done=1 for exactly one cycle.
- Frame shape: sout_valid is high for exactly WIDTH consecutive cycles. Back-to-back frames always have at least one IDLE cycle between them, with q=IDLE_LEVEL and load_ready=1 in that gap.
- load_valid while busy: ignored. pdata changes during SHIFT have no effect on the frame in progress. A load still pending is accepted in the next IDLE cycle.
- done: never asserted by reset. It is never high in the same cycle as sout_valid.
- Reset mid-frame: the frame is abandoned immediately. Outputs take their reset values, no done pulse is produced, and no partial word is retained.
- Counter: unsigned, sized to hold WIDTH+1. It never wraps in legal operation.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - After the WIDTH-th data bit, the block enters PARITY for one cycle.
  - q = even-parity bit of the captured word (XOR of all captured bits, so data plus parity has an even count of ones).
  - sout_valid stays high, so a frame lasts WIDTH+1 cycles.
  - done pulses in the IDLE cycle after the parity bit.
- When undefined: the PARITY state and its logic are absent, and frames are exactly WIDTH bits.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles with load_valid=1, then release.
  - Required: q=0, sout_valid=0, busy=0, done=0 throughout reset; load_ready=1 on the first cycle after release.
- MSB-first frame:
  - Stimulus: WIDTH=8, MSB_FIRST=1, single load of 8'hC1.
  - Required: q=1,1,0,0,0,0,0,1 on 8 consecutive cycles with sout_valid=1; next cycle q=0, sout_valid=0, done=1; the following cycle done=0.
- LSB-first frame:
  - Stimulus: WIDTH=8, MSB_FIRST=0, load 8'h1E.
  - Required: q=0,1,1,1,1,0,0,0.
- Back-to-back with load held:
  - Stimulus: hold load_valid=1 continuously, with 8'hFF then 8'h00 presented.
  - Required: 8 ones, then exactly one IDLE cycle (q=0, done=1, load_ready=1), then 8 zeros. A pdata change mid-frame does not alter the bits being sent.
- Reset mid-frame:
  - Stimulus: assert rst=0 while the 4th bit of 8'hA5 is on q.
  - Required: q=0, sout_valid=0 immediately, no done pulse; after release, a new load of 8'h5A transmits correctly.
- PISO_PARITY_EN defined:
  - Stimulus: load 8'hC1.
  - Required: 8 data bits, then parity bit q=1 with sout_valid=1 (9 cycles total), then done=1. A load of 8'h03 gives parity bit 0.
